// File: rtl/uart_receiver.sv
// UART receiver with 16x oversampling: two-flop rx synchronizer, mid-bit sampling,
// stop-bit framing error flag, and break suppression via an "armed" flag.
module uart_receiver #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
    localparam logic [3:0]    T_MID  = 4'd7;
    localparam logic [3:0]    T_BIT  = 4'd15;
    localparam logic [3:0]    T_STOP = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             t_q, t_d;
    logic [NW-1:0]          n_q, n_d;
    logic [DATA_BITS-1:0]   b_q, b_d;
    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
    logic                   armed_q, armed_d;
    logic                   rx_meta_q, rx_s_q;

    // State register: everything resets asynchronously; synchronizer idles high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            t_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            armed_q   <= 1'b1;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            n_q       <= n_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            armed_q   <= armed_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        armed_d = armed_q;

        unique case (state_q)
            IDLE: begin
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    t_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (t_q == T_MID) begin
                        // A start bit that is high again at mid-bit was only a glitch
                        if (!rx_s_q) begin
                            state_d = DATA;
                            t_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        t_d = t_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (t_q == T_BIT) begin
                        t_d = '0;
                        b_d = {rx_s_q, b_q[DATA_BITS-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        t_d = t_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (t_q == T_STOP) begin
                        state_d = IDLE;
                        dout_d  = b_q;
                        done_d  = 1'b1;
                        ferr_d  = ~rx_s_q;
                        // A low stop bit disarms until the line returns high (break)
                        if (!rx_s_q) begin
                            armed_d = 1'b0;
                        end
                    end else begin
                        t_d = t_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        dout         = dout_q;
        rx_done_tick = done_q;
        frame_err    = ferr_q;
        busy         = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of frames plus hand-written sequences
// for glitch, break, back-to-back and mid-frame reset.
module tb_uart_receiver;

    localparam int DATA_BITS = 8;
    localparam int SB_TICK   = 16;
    localparam int BIT_CLKS  = 64;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 s_tick = 1'b0;
    logic                 rx = 1'b1;
    logic [DATA_BITS-1:0] dout;
    logic                 rx_done_tick;
    logic                 frame_err;
    logic                 busy;

    uart_receiver #(.DATA_BITS(DATA_BITS), .SB_TICK(SB_TICK)) dut (
        .clock        (clock),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // One-clock s_tick every 4 clocks, free running
    logic [1:0] div_q = 2'd0;
    always @(posedge clock) begin
        div_q  <= div_q + 2'd1;
        s_tick <= (div_q == 2'd3);
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   pulse_cyc[$];
    logic [7:0] pulse_dout[$];
    logic pulse_ferr[$];
    int   busy_cnt = 0;
    always @(negedge clock) begin
        if (rx_done_tick) begin
            pulse_cyc.push_back(cyc);
            pulse_dout.push_back(dout);
            pulse_ferr.push_back(frame_err);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic hold_bit(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        hold_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold_bit(data[i], BIT_CLKS);
        hold_bit(stop, BIT_CLKS);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base;
        int bbase;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 8'h01, 1'b0};
        vecs[2] = '{8'h80, 1'b1, 8'h80, 1'b0};
        vecs[3] = '{8'h96, 1'b0, 8'h96, 1'b1};
        vecs[4] = '{8'h5A, 1'b1, 8'h5A, 1'b0};

        // Reset held low for 3 clocks
        repeat (3) @(negedge clock);
        check("rst_low_dout", dout, 0);
        check("rst_low_done", rx_done_tick, 0);
        check("rst_low_ferr", frame_err, 0);
        check("rst_low_busy", busy, 0);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("rst_rel_dout", dout, 0);
        check("rst_rel_done", rx_done_tick, 0);
        check("rst_rel_ferr", frame_err, 0);
        check("rst_rel_busy", busy, 0);

        // Table of single frames
        for (int i = 0; i < 5; i++) begin
            base = pulse_cyc.size();
            send_frame(vecs[i].data, vecs[i].stop);
            hold_bit(1'b1, 2 * BIT_CLKS);
            check($sformatf("vec%0d_pulses", i), pulse_cyc.size() - base, 1);
            if (pulse_cyc.size() > base) begin
                check($sformatf("vec%0d_dout", i), pulse_dout[base], vecs[i].exp_dout);
                check($sformatf("vec%0d_ferr", i), pulse_ferr[base], vecs[i].exp_ferr);
            end else begin
                check($sformatf("vec%0d_nopulse", i), 1, 0);
            end
            check($sformatf("vec%0d_busy", i), busy, 0);
        end

        // Glitch: 12 clocks low is rejected at mid start bit
        base  = pulse_cyc.size();
        bbase = busy_cnt;
        hold_bit(1'b0, 12);
        hold_bit(1'b1, 2 * BIT_CLKS);
        check("glitch_busy_seen", busy_cnt > bbase, 1);
        check("glitch_pulses", pulse_cyc.size() - base, 0);
        check("glitch_dout", dout, 8'h5A);
        check("glitch_busy_end", busy, 0);

        // Stop bit 0 followed by a 30-bit break
        base = pulse_cyc.size();
        send_frame(8'h3C, 1'b0);
        hold_bit(1'b0, 30 * BIT_CLKS);
        check("break_pulses", pulse_cyc.size() - base, 1);
        if (pulse_cyc.size() > base) begin
            check("break_dout", pulse_dout[base], 8'h3C);
            check("break_ferr", pulse_ferr[base], 1);
        end else begin
            check("break_nopulse", 1, 0);
        end
        hold_bit(1'b1, 2 * BIT_CLKS);
        check("break_after_pulses", pulse_cyc.size() - base, 1);
        check("break_dout_hold", dout, 8'h3C);

        // Back-to-back frames, one stop bit each
        base = pulse_cyc.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold_bit(1'b1, 2 * BIT_CLKS);
        check("b2b_pulses", pulse_cyc.size() - base, 2);
        if (pulse_cyc.size() >= base + 2) begin
            check("b2b_spacing", pulse_cyc[base+1] - pulse_cyc[base], 640);
            check("b2b_dout0", pulse_dout[base], 8'h00);
            check("b2b_dout1", pulse_dout[base+1], 8'hFF);
            check("b2b_ferr0", pulse_ferr[base], 0);
            check("b2b_ferr1", pulse_ferr[base+1], 0);
        end else begin
            check("b2b_nopulse", 1, 0);
        end

        // Reset pulse in the middle of data bit 3
        base = pulse_cyc.size();
        hold_bit(1'b0, BIT_CLKS);
        hold_bit(1'b1, BIT_CLKS);
        hold_bit(1'b0, BIT_CLKS);
        hold_bit(1'b1, BIT_CLKS);
        hold_bit(1'b1, BIT_CLKS / 2);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_rst_dout", dout, 0);
        check("abort_rst_busy", busy, 0);
        reset = 1'b1;
        hold_bit(1'b1, 2 * BIT_CLKS);
        check("abort_pulses", pulse_cyc.size() - base, 0);
        check("abort_dout", dout, 0);
        send_frame(8'h55, 1'b1);
        hold_bit(1'b1, 2 * BIT_CLKS);
        check("post_abort_pulses", pulse_cyc.size() - base, 1);
        check("post_abort_dout", dout, 8'h55);
        check("post_abort_ferr", (pulse_cyc.size() > base) ? pulse_ferr[base] : 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
